fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC and issues instruction-memory reads. It selects the next PC from sequential, branch, jump, JR and JAL sources, and drives the IF/ID latch that feeds the decode stage. It handles load-use stalls, redirect flushes and halt, and holds a redirect that arrives while a fetch is still outstanding.

Parameters:
PC_INIT, 32'h00000000, PC value loaded at reset.
NOP_INST, 32'h00000000, instruction word injected into IF/ID on flush/bubble.

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
ihit  in  1  instruction memory returned imemload this cycle
dhit  in  1  data-memory hit; advances IF/ID when no ihit (matches decode latch rule)
imemload  in  32  fetched instruction word
imemREN  out  1  instruction read request
imemaddr  out  32  current PC
load_use  in  1  hazard unit stall; hold PC and IF/ID
redirect  in  1  branch/jump resolved taken this cycle
redirect_sel  in  2  00 branch, 01 J/JAL, 10 JR
branch_target  in  32  PC+4 + (SignExt<<2), from execute
jump_addr  in  32  {pc4[31:28], target, 2'b00}
jr_addr  in  32  register-file rs value
halt  in  1  halt decoded downstream; freeze fetch
instruction  out  32  IF/ID instruction
inst_addr  out  32  IF/ID PC of that instruction
pp4_out  out  32  IF/ID PC+4
valid  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (async): state=FETCH; PC=PC_INIT; instruction=NOP_INST; inst_addr=0; pp4_out=0; valid=0; pending target=0.
- imemaddr = PC at all times. imemREN = 1 in FETCH and RWAIT, 0 in HALTED.
- States:
  - FETCH: normal operation.
  - RWAIT: a redirect is pending while ihit is low.
  - HALTED: terminal until reset.
- FETCH, priority order:
  1. halt=1: go to HALTED. IF/ID loads NOP, valid=0. PC holds.
  2. redirect=1 with ihit=1: PC <= selected target. IF/ID loads NOP, valid=0 (flush). Stay in FETCH.
  3. redirect=1 with ihit=0: capture target into pend_pc and go to RWAIT. IF/ID loads NOP, valid=0.
  4. load_use=1: PC and IF/ID hold, even if ihit=1. The instruction is refetched later.
  5. ihit=1: PC <= PC+4. IF/ID <= {imemload, PC, PC+4}, valid=1.
  6. dhit=1 without ihit: IF/ID loads NOP, valid=0 (bubble). PC holds.
  7. Otherwise: everything holds.
- RWAIT: PC holds the stale address. On ihit=1, the returned word is discarded, PC <= pend_pc, and state returns to FETCH. While waiting, IF/ID stays NOP. A new redirect in RWAIT overwrites pend_pc (last wins). halt in RWAIT goes to HALTED.
- HALTED: PC, IF/ID and pend_pc frozen. All inputs are ignored.
- Target select: 00 uses branch_target, 01 uses jump_addr, 10 uses jr_addr. 11 is illegal and is treated as no redirect. A simulation assertion flags it.
- PC+4 wraps modulo 2^32: 32'hFFFFFFFC+4 = 0.
- Simultaneous redirect and load_use: redirect wins. The stalled instruction is on the wrong path.
- Latency: one instruction per ihit. Redirect penalty is one bubble when ihit is coincident, otherwise one bubble plus the remaining wait.
- Reset mid-RWAIT discards pend_pc. Fetch restarts at PC_INIT.

Decomposition:
- cpu_types_pkg gains:
  - word_t (existing).
  - typedef enum logic[1:0] {REDIR_BR, REDIR_J, REDIR_JR} redir_t.
  - typedef enum logic[1:0] {FETCH, RWAIT, HALTED} fetch_state_t.
  - constant NOP_WORD.
- fetch_if.vh: interface with a .fe modport bundling the ports above.
- Sub-module fetch_pc_sel: combinational target mux plus PC+4 adder. Instantiated once.

Test Plan:
- Reset then ihit held 1 for 3 cycles from PC_INIT=0 -> imemaddr 0,4,8,C; IF/ID shows inst_addr 0,4,8 with valid=1, pp4_out 4,8,C.
- load_use=1 for 2 cycles with ihit=1 at PC=8 -> PC stays 8 and IF/ID unchanged both cycles. Release -> IF/ID gets inst@8.
- redirect=1, sel=00, branch_target=0x40 with ihit=1 at PC=0x10 -> next imemaddr=0x40. IF/ID valid=0 for one cycle.
- Redirect sel=10, jr_addr=0x100 while ihit=0 at PC=0x20, ihit arrives 3 cycles later -> word at 0x20 discarded, imemaddr becomes 0x100. A second redirect to 0x200 during the wait gives 0x200 instead.
- halt=1 -> imemREN=0 next cycle. PC and IF/ID frozen for 10 cycles despite ihit/redirect toggling. Only nRST recovers, to PC_INIT.
- PC=0xFFFFFFFC, ihit=1 -> PC wraps to 0x00000000 and pp4_out=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: word type, redirect source encoding and fetch FSM states.
package fetch_stage_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        REDIR_BR = 2'b00,
        REDIR_J  = 2'b01,
        REDIR_JR = 2'b10
    } redir_t;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        RWAIT  = 2'b01,
        HALTED = 2'b10
    } fetch_state_t;

    localparam word_t NOP_WORD   = 32'h0000_0000;
    localparam word_t WORD_BYTES = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: imem handshake, hazard/redirect controls and the IF/ID latch outputs.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic       ihit;
    logic       dhit;
    word_t      imemload;
    logic       imemREN;
    word_t      imemaddr;
    logic       load_use;
    logic       redirect;
    logic [1:0] redirect_sel;
    word_t      branch_target;
    word_t      jump_addr;
    word_t      jr_addr;
    logic       halt;
    word_t      instruction;
    word_t      inst_addr;
    word_t      pp4_out;
    logic       valid;

    // Fetch stage side
    modport fe (
        input  ihit, dhit, imemload, load_use, redirect, redirect_sel,
               branch_target, jump_addr, jr_addr, halt,
        output imemREN, imemaddr, instruction, inst_addr, pp4_out, valid
    );

    // Rest of the pipeline / memory side
    modport cpu (
        output ihit, dhit, imemload, load_use, redirect, redirect_sel,
               branch_target, jump_addr, jr_addr, halt,
        input  imemREN, imemaddr, instruction, inst_addr, pp4_out, valid
    );

endinterface

// File: rtl/fetch_stage_pc_sel.sv
// Redirect target mux and sequential PC+4 adder (wraps modulo 2^32).
module fetch_stage_pc_sel
    import fetch_stage_pkg::*;
(
    input  word_t      pc,
    input  logic [1:0] sel,
    input  word_t      branch_target,
    input  word_t      jump_addr,
    input  word_t      jr_addr,
    output word_t      target_c,
    output word_t      pc4_c,
    output logic       sel_ok_c
);

    // Encoding 11 has no source; flagged so the caller ignores the redirect
    always_comb begin
        target_c = branch_target;
        sel_ok_c = 1'b1;
        case (sel)
            2'(REDIR_BR): target_c = branch_target;
            2'(REDIR_J):  target_c = jump_addr;
            2'(REDIR_JR): target_c = jr_addr;
            default:      sel_ok_c = 1'b0;
        endcase
    end

    assign pc4_c = pc + WORD_BYTES;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues imem reads and drives the IF/ID latch.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t PC_INIT  = 32'h0000_0000,
    parameter word_t NOP_INST = NOP_WORD
) (
    input  logic     CLK,
    input  logic     nRST,
    fetch_stage_if.fe fif
);

    fetch_state_t state;
    word_t        pc;
    word_t        pend_pc;
    word_t        ifid_inst;
    word_t        ifid_addr;
    word_t        ifid_pp4;
    logic         ifid_valid;

    word_t target_c;
    word_t pc4_c;
    logic  sel_ok_c;
    logic  redir_c;

    fetch_stage_pc_sel u_pc_sel (
        .pc            (pc),
        .sel           (fif.redirect_sel),
        .branch_target (fif.branch_target),
        .jump_addr     (fif.jump_addr),
        .jr_addr       (fif.jr_addr),
        .target_c      (target_c),
        .pc4_c         (pc4_c),
        .sel_ok_c      (sel_ok_c)
    );

    assign redir_c = fif.redirect && sel_ok_c;

    // Fetch FSM together with PC, pending target and IF/ID latch
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            pend_pc    <= '0;
            ifid_inst  <= NOP_INST;
            ifid_addr  <= '0;
            ifid_pp4   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (fif.halt) begin
                        state      <= HALTED;
                        ifid_inst  <= NOP_INST;
                        ifid_addr  <= '0;
                        ifid_pp4   <= '0;
                        ifid_valid <= 1'b0;
                    end else if (redir_c) begin
                        // Redirect beats load_use: the stalled word is on the wrong path
                        ifid_inst  <= NOP_INST;
                        ifid_addr  <= '0;
                        ifid_pp4   <= '0;
                        ifid_valid <= 1'b0;
                        if (fif.ihit) begin
                            pc <= target_c;
                        end else begin
                            pend_pc <= target_c;
                            state   <= RWAIT;
                        end
                    end else if (fif.load_use) begin
                        state <= FETCH;
                    end else if (fif.ihit) begin
                        pc         <= pc4_c;
                        ifid_inst  <= fif.imemload;
                        ifid_addr  <= pc;
                        ifid_pp4   <= pc4_c;
                        ifid_valid <= 1'b1;
                    end else if (fif.dhit) begin
                        ifid_inst  <= NOP_INST;
                        ifid_addr  <= '0;
                        ifid_pp4   <= '0;
                        ifid_valid <= 1'b0;
                    end
                end
                RWAIT: begin
                    // Outstanding read to the stale PC must finish before we jump
                    if (fif.halt) begin
                        state <= HALTED;
                    end else if (fif.ihit) begin
                        pc    <= redir_c ? target_c : pend_pc;
                        state <= FETCH;
                    end else if (redir_c) begin
                        pend_pc <= target_c;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign fif.imemREN     = (state != HALTED);
    assign fif.imemaddr    = pc;
    assign fif.instruction = ifid_inst;
    assign fif.inst_addr   = ifid_addr;
    assign fif.pp4_out     = ifid_pp4;
    assign fif.valid       = ifid_valid;

    a_redirect_sel_legal : assert property (
        @(posedge CLK) disable iff (!nRST)
        (state == HALTED) || !(fif.redirect && fif.redirect_sel == 2'b11)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: IF/ID contents checked through a scoreboard queue.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] pp4;
    } exp_t;

    logic CLK;
    logic nRST;
    int   passed;
    int   total;
    exp_t exp_q[$];

    fetch_stage_if fif ();

    fetch_stage #(
        .PC_INIT  (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .fif  (fif)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Instruction memory model: word depends only on the requested address
    always_comb fif.imemload = mem_word(fif.imemaddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] p4);
        exp_t e;
        e.addr = a;
        e.pp4  = p4;
        exp_q.push_back(e);
    endtask

    // Monitor: each newly latched valid instruction is matched against the queue head
    logic        last_v;
    logic [31:0] last_a;
    initial begin
        exp_t e;
        last_v = 1'b0;
        last_a = '0;
        forever begin
            @(negedge CLK);
            if (fif.valid === 1'b1 && (!last_v || fif.inst_addr !== last_a)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL sb_unexpected: got addr %h expected no IF/ID entry", fif.inst_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_inst_addr", fif.inst_addr, e.addr);
                    chk("sb_pp4_out", fif.pp4_out, e.pp4);
                    chk("sb_instruction", fif.instruction, mem_word(e.addr));
                end
            end
            last_v = (fif.valid === 1'b1);
            last_a = fif.inst_addr;
        end
    end

    initial begin
        passed = 0;
        total  = 0;
        nRST   = 1'b0;
        fif.ihit = 1'b0;
        fif.dhit = 1'b0;
        fif.load_use = 1'b0;
        fif.redirect = 1'b0;
        fif.redirect_sel = 2'b00;
        fif.branch_target = '0;
        fif.jump_addr = '0;
        fif.jr_addr = '0;
        fif.halt = 1'b0;

        repeat (2) step();
        chk("rst_imemaddr", fif.imemaddr, 32'h0);
        chk("rst_imemREN", 32'(fif.imemREN), 32'h1);
        chk("rst_valid", 32'(fif.valid), 32'h0);
        chk("rst_instruction", fif.instruction, 32'h0);
        chk("rst_inst_addr", fif.inst_addr, 32'h0);
        chk("rst_pp4_out", fif.pp4_out, 32'h0);
        nRST = 1'b1;

        // Sequential fetch
        fif.ihit = 1'b1;
        push(32'h0, 32'h4); step(); chk("seq_pc1", fif.imemaddr, 32'h4);
        push(32'h4, 32'h8); step(); chk("seq_pc2", fif.imemaddr, 32'h8);
        push(32'h8, 32'hC); step(); chk("seq_pc3", fif.imemaddr, 32'hC);

        // Load-use stall holds PC and IF/ID
        fif.load_use = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("lu_pc_hold", fif.imemaddr, 32'hC);
            chk("lu_ifid_hold", fif.inst_addr, 32'h8);
            chk("lu_valid_hold", 32'(fif.valid), 32'h1);
        end
        fif.load_use = 1'b0;
        push(32'hC, 32'h10); step(); chk("lu_release_pc", fif.imemaddr, 32'h10);

        // Branch redirect coincident with ihit
        fif.redirect = 1'b1; fif.redirect_sel = 2'b00; fif.branch_target = 32'h40;
        step();
        chk("br_pc", fif.imemaddr, 32'h40);
        chk("br_flush_valid", 32'(fif.valid), 32'h0);
        fif.redirect = 1'b0;
        push(32'h40, 32'h44); step(); chk("br_next_pc", fif.imemaddr, 32'h44);

        // Jump redirect wins over simultaneous load_use
        fif.redirect = 1'b1; fif.redirect_sel = 2'b01; fif.jump_addr = 32'h80; fif.load_use = 1'b1;
        step();
        chk("j_lu_pc", fif.imemaddr, 32'h80);
        chk("j_lu_valid", 32'(fif.valid), 32'h0);
        fif.redirect = 1'b0; fif.load_use = 1'b0;
        push(32'h80, 32'h84); step(); chk("j_next_pc", fif.imemaddr, 32'h84);

        // JR redirect while the read is outstanding
        fif.ihit = 1'b0;
        fif.redirect = 1'b1; fif.redirect_sel = 2'b10; fif.jr_addr = 32'h100;
        step();
        chk("rw_pc_stale", fif.imemaddr, 32'h84);
        chk("rw_valid", 32'(fif.valid), 32'h0);
        fif.redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rw_wait_pc", fif.imemaddr, 32'h84);
            chk("rw_wait_ren", 32'(fif.imemREN), 32'h1);
        end
        fif.ihit = 1'b1;
        step();
        chk("rw_done_pc", fif.imemaddr, 32'h100);
        chk("rw_done_valid", 32'(fif.valid), 32'h0);
        push(32'h100, 32'h104); step(); chk("rw_next_pc", fif.imemaddr, 32'h104);

        // Second redirect during the wait overwrites the pending target
        fif.ihit = 1'b0;
        fif.redirect = 1'b1; fif.redirect_sel = 2'b10; fif.jr_addr = 32'h100;
        step();
        fif.jr_addr = 32'h200;
        step();
        chk("rw2_pc_stale", fif.imemaddr, 32'h104);
        fif.redirect = 1'b0; fif.ihit = 1'b1;
        step();
        chk("rw2_last_wins", fif.imemaddr, 32'h200);
        push(32'h200, 32'h204); step(); chk("rw2_next_pc", fif.imemaddr, 32'h204);

        // dhit without ihit inserts a bubble
        fif.ihit = 1'b0; fif.dhit = 1'b1;
        step();
        chk("dhit_valid", 32'(fif.valid), 32'h0);
        chk("dhit_pc", fif.imemaddr, 32'h204);
        fif.dhit = 1'b0;
        step();
        chk("idle_pc", fif.imemaddr, 32'h204);
        fif.ihit = 1'b1;
        push(32'h204, 32'h208); step(); chk("dhit_next_pc", fif.imemaddr, 32'h208);

        // PC+4 wraps at the top of the address space
        fif.redirect = 1'b1; fif.redirect_sel = 2'b10; fif.jr_addr = 32'hFFFF_FFFC;
        step();
        chk("wrap_top_pc", fif.imemaddr, 32'hFFFF_FFFC);
        fif.redirect = 1'b0;
        push(32'hFFFF_FFFC, 32'h0); step();
        chk("wrap_pc", fif.imemaddr, 32'h0);
        chk("wrap_pp4", fif.pp4_out, 32'h0);
        push(32'h0, 32'h4); step(); chk("wrap_next_pc", fif.imemaddr, 32'h4);

        // Halt freezes everything until reset
        fif.halt = 1'b1;
        step();
        chk("halt_ren", 32'(fif.imemREN), 32'h0);
        chk("halt_pc", fif.imemaddr, 32'h4);
        chk("halt_instruction", fif.instruction, 32'h0);
        fif.halt = 1'b0;
        fif.branch_target = 32'h300; fif.redirect_sel = 2'b00;
        for (int i = 0; i < 10; i++) begin
            fif.ihit = i[0];
            fif.redirect = ~i[0];
            fif.load_use = i[1];
            fif.dhit = i[2];
            step();
            chk("halted_pc", fif.imemaddr, 32'h4);
            chk("halted_ren", 32'(fif.imemREN), 32'h0);
            chk("halted_valid", 32'(fif.valid), 32'h0);
        end
        fif.ihit = 1'b0; fif.redirect = 1'b0; fif.load_use = 1'b0; fif.dhit = 1'b0;
        nRST = 1'b0;
        #1;
        chk("rehalt_rst_pc", fif.imemaddr, 32'h0);
        chk("rehalt_rst_ren", 32'(fif.imemREN), 32'h1);
        step();
        nRST = 1'b1;
        fif.ihit = 1'b1;
        push(32'h0, 32'h4); step(); chk("restart_pc", fif.imemaddr, 32'h4);
        fif.ihit = 1'b0;
        repeat (2) step();

        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
